// File: rtl/wb_arbiter.sv
// Two-master pipelined Wishbone B4 arbiter (M0 = fetch, M1 = data) with bus-cycle grant lock
// and a no-ACK watchdog that aborts a hung cycle with a one-cycle ERR to the owner.
module wb_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int TIMEOUT     = 15,
    parameter int M1_PRIORITY = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            m0_wb_cyc_i,
    input  logic            m0_wb_stb_i,
    output logic            m0_wb_stall_o,
    input  logic            m0_wb_we_i,
    input  logic [AW-1:0]   m0_wb_addr_i,
    input  logic [DW/8-1:0] m0_wb_sel_i,
    input  logic [DW-1:0]   m0_wb_dat_i,
    output logic            m0_wb_ack_o,
    output logic            m0_wb_err_o,
    output logic [DW-1:0]   m0_wb_dat_o,
    input  logic            m1_wb_cyc_i,
    input  logic            m1_wb_stb_i,
    output logic            m1_wb_stall_o,
    input  logic            m1_wb_we_i,
    input  logic [AW-1:0]   m1_wb_addr_i,
    input  logic [DW/8-1:0] m1_wb_sel_i,
    input  logic [DW-1:0]   m1_wb_dat_i,
    output logic            m1_wb_ack_o,
    output logic            m1_wb_err_o,
    output logic [DW-1:0]   m1_wb_dat_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic            wb_stall_i,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i
);
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    logic [3:0] outst_q, outst_d;
    logic [7:0] timer_q, timer_d;

    logic            g_cyc, g_stb, g_we, o_cyc;
    logic [AW-1:0]   g_addr;
    logic [DW/8-1:0] g_sel;
    logic [DW-1:0]   g_dat;
    logic            busy, accept, ack_cnt, timeout;

    assign g_cyc  = gnt_q ? m1_wb_cyc_i  : m0_wb_cyc_i;
    assign g_stb  = gnt_q ? m1_wb_stb_i  : m0_wb_stb_i;
    assign g_we   = gnt_q ? m1_wb_we_i   : m0_wb_we_i;
    assign g_addr = gnt_q ? m1_wb_addr_i : m0_wb_addr_i;
    assign g_sel  = gnt_q ? m1_wb_sel_i  : m0_wb_sel_i;
    assign g_dat  = gnt_q ? m1_wb_dat_i  : m0_wb_dat_i;
    assign o_cyc  = gnt_q ? m0_wb_cyc_i  : m1_wb_cyc_i;

    assign busy    = (state_q == BUSY);
    assign accept  = g_stb & ~wb_stall_i;
    assign ack_cnt = wb_ack_i & (outst_q != 4'd0);
    // A master that already dropped CYC walked away legally; no ERR for it.
    assign timeout = busy & g_cyc & (outst_q != 4'd0) & (timer_q == TMAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b0;
            outst_q <= 4'd0;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        outst_d = outst_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                outst_d = 4'd0;
                timer_d = 8'd0;
                if (m0_wb_cyc_i || m1_wb_cyc_i) begin
                    state_d = BUSY;
                    if (m0_wb_cyc_i && m1_wb_cyc_i)
                        gnt_d = (M1_PRIORITY != 0) ? 1'b1 : ~last_q;
                    else
                        gnt_d = m1_wb_cyc_i;
                end
            end
            BUSY, ABORT: begin
                if (!g_cyc) begin
                    // End of bus cycle: hand straight over if the other side is waiting.
                    last_d  = gnt_q;
                    outst_d = 4'd0;
                    timer_d = 8'd0;
                    if (o_cyc) begin
                        state_d = BUSY;
                        gnt_d   = ~gnt_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q == BUSY) begin
                    if (timeout) begin
                        state_d = ABORT;
                        outst_d = 4'd0;
                        timer_d = 8'd0;
                    end else begin
                        outst_d = outst_q + {3'd0, accept} - {3'd0, ack_cnt};
                        timer_d = (wb_ack_i || accept || outst_q == 4'd0) ? 8'd0 : timer_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_cyc_o  = busy & g_cyc;
    assign wb_stb_o  = busy & g_stb;
    assign wb_we_o   = busy & g_we;
    assign wb_addr_o = busy ? g_addr : '0;
    assign wb_sel_o  = busy ? g_sel  : '0;
    assign wb_dat_o  = busy ? g_dat  : '0;

    assign m0_wb_stall_o = (busy && !gnt_q) ? wb_stall_i : 1'b1;
    assign m1_wb_stall_o = (busy &&  gnt_q) ? wb_stall_i : 1'b1;
    assign m0_wb_ack_o   = busy & ~gnt_q & wb_ack_i;
    assign m1_wb_ack_o   = busy &  gnt_q & wb_ack_i;
    assign m0_wb_err_o   = timeout & ~gnt_q;
    assign m1_wb_err_o   = timeout &  gnt_q;
    assign m0_wb_dat_o   = wb_dat_i;
    assign m1_wb_dat_o   = wb_dat_i;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed table, grant/timeout/reset sequences and a randomized run
// against a transaction-level reference, on a fixed-priority and a round-robin instance.
module tb_wb_arbiter;
    localparam int AW = 16, DW = 16, SW = DW / 8, TO = 15;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, stall, ack;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [SW-1:0] m0_sel, m1_sel;
    logic [DW-1:0] m0_wdat, m1_wdat, sdat;
    logic [1:0][74:0] act;

    for (genvar g = 0; g < 2; g++) begin : u
        logic wcyc, wstb, wwe, s0, a0, e0, s1, a1, e1;
        logic [AW-1:0] waddr;
        logic [SW-1:0] wsel;
        logic [DW-1:0] wdat, d0, d1;
        wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .M1_PRIORITY(g == 0 ? 1 : 0)) dut (
            .clk_i(clk), .rst_ni(rst_n),
            .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_stall_o(s0), .m0_wb_we_i(m0_we),
            .m0_wb_addr_i(m0_addr), .m0_wb_sel_i(m0_sel), .m0_wb_dat_i(m0_wdat),
            .m0_wb_ack_o(a0), .m0_wb_err_o(e0), .m0_wb_dat_o(d0),
            .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_stall_o(s1), .m1_wb_we_i(m1_we),
            .m1_wb_addr_i(m1_addr), .m1_wb_sel_i(m1_sel), .m1_wb_dat_i(m1_wdat),
            .m1_wb_ack_o(a1), .m1_wb_err_o(e1), .m1_wb_dat_o(d1),
            .wb_cyc_o(wcyc), .wb_stb_o(wstb), .wb_we_o(wwe), .wb_addr_o(waddr),
            .wb_sel_o(wsel), .wb_dat_o(wdat),
            .wb_stall_i(stall), .wb_ack_i(ack), .wb_dat_i(sdat));
        assign act[g] = {wcyc, wstb, wwe, waddr, wsel, wdat, s0, a0, e0, d0, s1, a1, e1, d1};
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [74:0] a, input logic [74:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, a, e);
    endtask

    // Reference: who owns the bus (-1 none), whether the owner's cycle was killed,
    // how many requests are unanswered and how many quiet cycles have gone by.
    typedef struct {
        int owner;
        bit killed;
        int last;
        int pend;
        int quiet;
    } mdl_t;

    function automatic logic [74:0] mexp(mdl_t s);
        bit live;
        logic gc, gs, gw, e, st0, st1, k0, k1;
        logic [AW-1:0] ga;
        logic [SW-1:0] gl;
        logic [DW-1:0] gd;
        live = (s.owner >= 0) && !s.killed;
        {gc, gs, gw, ga, gl, gd} = '0;
        if (live && s.owner == 1) {gc, gs, gw, ga, gl, gd} = {m1_cyc, m1_stb, m1_we, m1_addr, m1_sel, m1_wdat};
        if (live && s.owner == 0) {gc, gs, gw, ga, gl, gd} = {m0_cyc, m0_stb, m0_we, m0_addr, m0_sel, m0_wdat};
        e   = live && gc && s.pend > 0 && s.quiet == TO - 1;
        st0 = (live && s.owner == 0) ? stall : 1'b1;
        st1 = (live && s.owner == 1) ? stall : 1'b1;
        k0  = live && s.owner == 0 && ack;
        k1  = live && s.owner == 1 && ack;
        return {gc, gs, gw, ga, gl, gd, st0, k0, e && s.owner == 0, sdat,
                st1, k1, e && s.owner == 1, sdat};
    endfunction

    function automatic mdl_t mnext(mdl_t s, int prio);
        mdl_t n;
        bit mine, theirs, took;
        n = s;
        if (s.owner < 0) begin
            if (m0_cyc && m1_cyc) n.owner = (prio != 0) ? 1 : 1 - s.last;
            else if (m0_cyc || m1_cyc) n.owner = m1_cyc ? 1 : 0;
            return n;
        end
        mine   = (s.owner == 1) ? m1_cyc : m0_cyc;
        theirs = (s.owner == 1) ? m0_cyc : m1_cyc;
        if (!mine) begin
            n.last = s.owner;
            n.owner = theirs ? 1 - s.owner : -1;
            n.killed = 0; n.pend = 0; n.quiet = 0;
        end else if (!s.killed) begin
            took = ((s.owner == 1) ? m1_stb : m0_stb) && !stall;
            if (s.pend > 0 && s.quiet == TO - 1) begin
                n.killed = 1; n.pend = 0; n.quiet = 0;
            end else begin
                n.quiet = (ack || took || s.pend == 0) ? 0 : s.quiet + 1;
                n.pend  = (s.pend + int'(took) - int'(ack && s.pend > 0)) % 16;
            end
        end
        return n;
    endfunction

    typedef struct packed {
        logic [5:0] in;   // m0_cyc m0_stb m1_cyc m1_stb stall ack
        logic [5:0] exp;  // wb_cyc wb_stb m0_stall m1_stall m0_ack m1_ack
    } vec_t;
    vec_t tbl [20];

    task automatic drive(input logic [5:0] v);
        {m0_cyc, m0_stb, m1_cyc, m1_stb, stall, ack} = v;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(6'b0);
        next_cycle();
        rst_n = 1'b1;
    endtask

    mdl_t mdl [2];
    int first_err, n_err;

    initial begin
        {m0_we, m1_we, m0_addr, m1_addr, m0_sel, m1_sel, m0_wdat, m1_wdat} = '0;
        sdat = 16'hBEEF;
        drive(6'b111100);
        m0_we = 1'b1; m0_addr = 16'h1234;
        // reset: slave side quiet, both masters stalled
        @(negedge clk);
        check("reset_p1", act[0], {37'd0, 1'b1, 2'b00, sdat, 1'b1, 2'b00, sdat});
        check("reset_rr", act[1], {37'd0, 1'b1, 2'b00, sdat, 1'b1, 2'b00, sdat});
        {m0_we, m0_addr} = '0;
        do_reset();

        // directed table: single read, simultaneous request, handover, stalled accept
        tbl[0]  = {6'b110000, 6'b001100}; tbl[1]  = {6'b110000, 6'b110100};
        tbl[2]  = {6'b100000, 6'b100100}; tbl[3]  = {6'b100001, 6'b100110};
        tbl[4]  = {6'b000000, 6'b000100}; tbl[5]  = {6'b000000, 6'b001100};
        tbl[6]  = {6'b111100, 6'b001100}; tbl[7]  = {6'b111100, 6'b111000};
        tbl[8]  = {6'b111001, 6'b101001}; tbl[9]  = {6'b110000, 6'b001000};
        tbl[10] = {6'b110000, 6'b110100}; tbl[11] = {6'b100001, 6'b100110};
        tbl[12] = {6'b000000, 6'b000100}; tbl[13] = {6'b000000, 6'b001100};
        tbl[14] = {6'b110010, 6'b001100}; tbl[15] = {6'b110010, 6'b111100};
        tbl[16] = {6'b110000, 6'b110100}; tbl[17] = {6'b100001, 6'b100110};
        tbl[18] = {6'b000000, 6'b000100}; tbl[19] = {6'b000000, 6'b001100};
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].in);
            @(negedge clk);
            check($sformatf("tbl%0d", i), 75'({u[0].wcyc, u[0].wstb, u[0].s0, u[0].s1, u[0].a0, u[0].a1}),
                  75'(tbl[i].exp));
            next_cycle();
        end

        // both request from IDLE repeatedly: fixed priority keeps M1, round-robin alternates
        do_reset();
        for (int r = 0; r < 4; r++) begin
            drive(6'b101000);
            next_cycle();
            @(negedge clk);
            check($sformatf("prio_gnt%0d", r), 75'({u[0].s0, u[0].s1}), 75'(2'b10));
            check($sformatf("rr_gnt%0d", r), 75'({u[1].s0, u[1].s1}), (r % 2 == 0) ? 75'(2'b10) : 75'(2'b01));
            next_cycle();
            drive(6'b000000);
            next_cycle();
        end

        // watchdog: one accepted stb, never acked
        do_reset();
        drive(6'b110000);
        next_cycle();
        @(negedge clk);
        check("to_accept", 75'({u[0].wcyc, u[0].wstb, u[0].s0}), 75'(3'b110));
        next_cycle();
        drive(6'b100000);
        first_err = -1; n_err = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (u[0].e0 || u[0].e1) begin
                n_err++;
                if (first_err < 0) first_err = k;
            end
            if (k == 16) check("to_cyc_drop", 75'({u[0].wcyc, u[0].s0}), 75'(2'b01));
            next_cycle();
        end
        check("to_err_cycle", 75'(first_err), 75'(15));
        check("to_err_width", 75'(n_err), 75'(1));
        drive(6'b100001);
        @(negedge clk);
        check("to_late_ack", 75'({u[0].a0, u[0].a1, u[0].wcyc}), 75'(3'b000));
        next_cycle();
        drive(6'b000000);
        next_cycle();

        // async reset with two requests outstanding
        do_reset();
        drive(6'b110000);
        next_cycle(); next_cycle(); next_cycle();
        drive(6'b100000);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 75'({u[0].wcyc, u[0].wstb, u[0].s0, u[0].a0, u[0].e0, u[0].waddr}),
                 75'({5'b00100, 16'h0}));
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_idle", 75'({u[0].wcyc, u[0].s0}), 75'(2'b01));
        next_cycle();
        @(negedge clk);
        check("rst_regrant", 75'({u[0].wcyc, u[0].s0, u[0].e0}), 75'(3'b100));
        next_cycle();
        drive(6'b000000);
        next_cycle();

        // randomized traffic against the reference
        do_reset();
        for (int g = 0; g < 2; g++) mdl[g] = '{owner: -1, killed: 0, last: 0, pend: 0, quiet: 0};
        for (int i = 0; i < 3000; i++) begin
            int stbp, ackp;
            stbp = (i < 1500) ? 40 : 8;
            ackp = (i < 1500) ? 50 : 3;
            m0_cyc  = m0_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            m1_cyc  = m1_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            m0_stb  = m0_cyc && ($urandom_range(99) < stbp);
            m1_stb  = m1_cyc && ($urandom_range(99) < stbp);
            m0_we   = 1'($urandom);      m1_we   = 1'($urandom);
            m0_addr = AW'($urandom);     m1_addr = AW'($urandom);
            m0_sel  = SW'($urandom);     m1_sel  = SW'($urandom);
            m0_wdat = DW'($urandom);     m1_wdat = DW'($urandom);
            stall   = ($urandom_range(99) < 30);
            ack     = ($urandom_range(99) < ackp);
            sdat    = DW'($urandom);
            @(negedge clk);
            check("rand_prio", act[0], mexp(mdl[0]));
            check("rand_rr", act[1], mexp(mdl[1]));
            mdl[0] = mnext(mdl[0], 1);
            mdl[1] = mnext(mdl[1], 0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
